// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  // Loader states; DONE and ERR are terminal until a start pulse.
  typedef enum logic [2:0] {
    HDR_HI = 3'd0,
    HDR_LO = 3'd1,
    DATA   = 3'd2,
    CSUM   = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_e;

  // Frame header is a big-endian word count of this many bytes.
  localparam int HDR_BYTES = 2;
  localparam int CNT_W     = 8 * HDR_BYTES;

  // States in which the loader is consuming stream bytes.
  function automatic logic is_rx(state_e s);
    return (s == HDR_HI) || (s == HDR_LO) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Stream, instruction-memory write and status bundle for imem_loader.
// slave: the loader side; master: the environment driving the stream.
interface imem_loader_if #(
  parameter int WL = 32,
  parameter int AW = 8
);
  logic          start;
  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_ready;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [WL-1:0] im_wd;
  logic          cpu_rst_n;
  logic          busy;
  logic          done;
  logic          err;

  modport slave (
    input  start, s_data, s_valid,
    output s_ready, im_we, im_addr, im_wd, cpu_rst_n, busy, done, err
  );

  modport master (
    output start, s_data, s_valid,
    input  s_ready, im_we, im_addr, im_wd, cpu_rst_n, busy, done, err
  );
endinterface

// File: rtl/imem_loader_packer.sv
// byte_to_word_packer: shifts bytes MSB-first into a word and pulses
// word_full_o on the byte that completes it. word_o is the completed
// word (including the current byte) and is meaningful with word_full_o.
module byte_to_word_packer #(
  parameter int WL = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          shift_en_i,
  input  logic [7:0]    shift_in_i,
  output logic [WL-1:0] word_o,
  output logic          word_full_o
);
  localparam int BPW = WL / 8;
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [BCW-1:0] LAST = BCW'(BPW - 1);

  logic [WL-1:0]  sr_q, sr_d;
  logic [BCW-1:0] cnt_q, cnt_d;

  // Next shift-register value and byte-in-word counter (wraps per word).
  always_comb begin
    sr_d  = (sr_q << 8) | WL'(shift_in_i);
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (shift_en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter is control and is reset; the shift register is pure data.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
    if (shift_en_i) begin
      sr_q <= sr_d;
    end
  end

  assign word_o      = sr_d;
  assign word_full_o = shift_en_i && (cnt_q == LAST);

endmodule

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader for instruction memory. Holds the
// core in reset until the whole image has been written.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing
// 8-bit XOR checksum byte over header and data.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int WL = 32,
  parameter int AW = 8
) (
  input logic         CLK,
  input logic         RST,
  imem_loader_if.slave bus
);
  localparam int               CAP_W = CNT_W + 1;
  localparam logic [CAP_W-1:0] CAP   = CAP_W'(2 ** AW);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e FRAME_END = CSUM;
`else
  localparam state_e FRAME_END = DONE;
`endif

  state_e          state_q, state_d;
  logic            s_ready_q, s_ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            cpu_rst_n_q;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] n_hdr;
  logic [AW:0]      widx_q, widx_inc;
  logic             im_we_q;
  logic [AW-1:0]    im_addr_q;
  logic [WL-1:0]    im_wd_q;

  logic            acc, restart, shift_en, word_full, last_word;
  logic [WL-1:0]   word;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]      csum_q;
`endif

  assign acc       = bus.s_valid && s_ready_q;
  assign restart   = bus.start && ((state_q == DONE) || (state_q == ERR));
  assign shift_en  = acc && (state_q == DATA);
  assign n_hdr     = {count_q[CNT_W-1:8], bus.s_data};
  assign widx_inc  = widx_q + 1'b1;
  assign last_word = (CAP_W'(widx_inc) == CAP_W'(count_q));

  byte_to_word_packer #(.WL(WL)) u_packer (
    .clk_i       (CLK),
    .rst_ni      (RST),
    .clear_i     (restart),
    .shift_en_i  (shift_en),
    .shift_in_i  (bus.s_data),
    .word_o      (word),
    .word_full_o (word_full)
  );

  // State register; status outputs are registered from the next state.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= HDR_HI;
      s_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_ready_q   <= s_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cpu_rst_n_q <= done_d;
    end
  end

  // Next-state logic: header parse, word counting, checksum, restart.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HDR_HI: if (acc) state_d = HDR_LO;
      HDR_LO: begin
        if (acc) begin
          if (CAP_W'(n_hdr) > CAP)   state_d = ERR;
          else if (n_hdr == '0)      state_d = FRAME_END;
          else                       state_d = DATA;
        end
      end
      DATA: if (word_full && last_word) state_d = FRAME_END;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: if (acc) state_d = (bus.s_data == csum_q) ? DONE : ERR;
`else
      CSUM: state_d = ERR;
`endif
      DONE, ERR: if (bus.start) state_d = HDR_HI;
      default: state_d = HDR_HI;
    endcase
  end

  // Output decode of the next state, registered above.
  always_comb begin
    s_ready_d = is_rx(state_d);
    busy_d    = is_rx(state_d);
    done_d    = (state_d == DONE);
    err_d     = (state_d == ERR);
  end

  // Word index and registered memory-write port.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      widx_q    <= '0;
      im_we_q   <= 1'b0;
      im_addr_q <= '0;
      im_wd_q   <= '0;
    end else begin
      im_we_q <= word_full;
      if (word_full) begin
        im_addr_q <= widx_q[AW-1:0];
        im_wd_q   <= word;
        widx_q    <= widx_inc;
      end
      if (restart) begin
        widx_q <= '0;
      end
    end
  end

  // Header word count latch; only read after both bytes are in.
  always_ff @(posedge CLK) begin
    if (acc && (state_q == HDR_HI)) count_q[CNT_W-1:8] <= bus.s_data;
    if (acc && (state_q == HDR_LO)) count_q[7:0]       <= bus.s_data;
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running XOR of header and data bytes.
  always_ff @(posedge CLK) begin
    if (!RST || restart) begin
      csum_q <= 8'h00;
    end else if (acc && (state_q != CSUM)) begin
      csum_q <= csum_q ^ bus.s_data;
    end
  end
`endif

  assign bus.s_ready   = s_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.cpu_rst_n = cpu_rst_n_q;
  assign bus.im_we     = im_we_q;
  assign bus.im_addr   = im_addr_q;
  assign bus.im_wd     = im_wd_q;

endmodule
